// File: rtl/gmsk_burst_sequencer_if.sv
// Handshake and symbol-stream bundle between a payload source / modulator
// and the GMSK burst sequencer.
interface gmsk_burst_sequencer_if;
    logic burst_start;
    logic payload_valid;
    logic payload_bit;
    logic payload_ready;
    logic sample_strobe;
    logic symbol_strobe;
    logic input_bit;
    logic burst_active;
    logic underrun;

    // Sequencer side: takes requests and payload, produces timebase and symbols
    modport slave (
        input  burst_start,
        input  payload_valid,
        input  payload_bit,
        output payload_ready,
        output sample_strobe,
        output symbol_strobe,
        output input_bit,
        output burst_active,
        output underrun
    );

    // Controller / payload source side
    modport master (
        output burst_start,
        output payload_valid,
        output payload_bit,
        input  payload_ready,
        input  sample_strobe,
        input  symbol_strobe,
        input  input_bit,
        input  burst_active,
        input  underrun
    );
endinterface

// File: rtl/gmsk_burst_sequencer.sv
// GMSK transmit front end: free-running sample/symbol timebase, burst framing
// (head tail, payload, end tail, guard) and differential encoding of the
// symbol stream fed to the modulator.
module gmsk_burst_sequencer #(
    parameter int CLOCKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SYMBOL = 128,
    parameter int PAYLOAD_BITS       = 142,
    parameter int TAIL_BITS          = 3,
    parameter int GUARD_BITS         = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    gmsk_burst_sequencer_if.slave  bus
);

    // A zero-length guard simply skips the GUARD state; the counter compare
    // still needs a legal terminal value.
    localparam int GUARD_N   = (GUARD_BITS > 0) ? GUARD_BITS : 1;
    localparam int SYM_MAX_A = (PAYLOAD_BITS > TAIL_BITS) ? PAYLOAD_BITS : TAIL_BITS;
    localparam int SYM_MAX   = (SYM_MAX_A > GUARD_N) ? SYM_MAX_A : GUARD_N;

    localparam int CLK_W  = (CLOCKS_PER_SAMPLE > 1)  ? $clog2(CLOCKS_PER_SAMPLE)  : 1;
    localparam int SAMP_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam int SYM_W  = (SYM_MAX > 1)            ? $clog2(SYM_MAX)            : 1;

    localparam logic [CLK_W-1:0]  CLK_LAST   = CLK_W'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [SYM_W-1:0]  TAIL_LAST  = SYM_W'(TAIL_BITS - 1);
    localparam logic [SYM_W-1:0]  PAY_LAST   = SYM_W'(PAYLOAD_BITS - 1);
    localparam logic [SYM_W-1:0]  GUARD_LAST = SYM_W'(GUARD_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        TAIL,
        GUARD
    } state_t;

    logic [CLK_W-1:0]  clk_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [SYM_W-1:0]  sym_cnt;
    state_t            state;
    state_t            next_state;
    logic              pending;
    logic              prev_d;
    logic              d;
    logic              sample_tick;
    logic              last_sample;
    logic              payload_req;
    logic              input_bit_q;
    logic              symbol_strobe_q;
    logic              burst_active_q;

    // Decode the sample tick and the last sample of the current symbol
    always_comb begin
        sample_tick = (clk_cnt == CLK_LAST);
        last_sample = sample_tick && (samp_cnt == SAMP_LAST);
    end

    // Free-running clock and sample counters; they never stop between bursts
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            if (sample_tick) begin
                clk_cnt <= '0;
                if (samp_cnt == SAMP_LAST) begin
                    samp_cnt <= '0;
                end else begin
                    samp_cnt <= samp_cnt + 1'b1;
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    // Next burst state and the raw data bit of the symbol emitted at the
    // coming boundary; d follows the state being entered or kept
    always_comb begin
        next_state = state;
        d          = 1'b1;
        case (state)
            IDLE: begin
                if (pending || bus.burst_start) begin
                    next_state = HEAD;
                end
            end
            HEAD: begin
                if (sym_cnt == TAIL_LAST) begin
                    next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (sym_cnt == PAY_LAST) begin
                    next_state = TAIL;
                end
            end
            TAIL: begin
                if (sym_cnt == TAIL_LAST) begin
                    next_state = (GUARD_BITS > 0) ? GUARD : IDLE;
                end
            end
            GUARD: begin
                if (sym_cnt == GUARD_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        case (next_state)
            HEAD, TAIL: d = 1'b0;
            PAYLOAD:    d = bus.payload_valid & bus.payload_bit;
            default:    d = 1'b1;
        endcase

        payload_req = last_sample && (next_state == PAYLOAD);
    end

    // Symbol boundary: emit the differentially encoded symbol, move the FSM
    // and the per-state symbol counter, and latch burst requests made in IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            sym_cnt         <= '0;
            pending         <= 1'b0;
            prev_d          <= 1'b1;
            input_bit_q     <= 1'b0;
            symbol_strobe_q <= 1'b0;
            burst_active_q  <= 1'b0;
        end else begin
            symbol_strobe_q <= last_sample;
            if (last_sample) begin
                input_bit_q    <= d ^ prev_d;
                prev_d         <= d;
                state          <= next_state;
                burst_active_q <= (next_state != IDLE);
                pending        <= 1'b0;
                if ((next_state != state) || (next_state == IDLE)) begin
                    sym_cnt <= '0;
                end else begin
                    sym_cnt <= sym_cnt + 1'b1;
                end
            end else if ((state == IDLE) && bus.burst_start) begin
                pending <= 1'b1;
            end
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.sample_strobe = sample_tick;
        bus.symbol_strobe = symbol_strobe_q;
        bus.input_bit     = input_bit_q;
        bus.burst_active  = burst_active_q;
        bus.payload_ready = payload_req;
        bus.underrun      = payload_req & ~bus.payload_valid;
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Scoreboard bench for gmsk_burst_sequencer: small-parameter instance for
// framing and handshake, a default instance for the symbol period and a
// fast-timebase instance with default burst lengths.
module tb_gmsk_burst_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset_aux = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    gmsk_burst_sequencer_if bus_a ();
    gmsk_burst_sequencer_if bus_b ();
    gmsk_burst_sequencer_if bus_c ();

    gmsk_burst_sequencer #(
        .CLOCKS_PER_SAMPLE (2),
        .SAMPLES_PER_SYMBOL(4),
        .PAYLOAD_BITS      (4),
        .TAIL_BITS         (3),
        .GUARD_BITS        (2)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a.slave)
    );

    gmsk_burst_sequencer dut_b (
        .clock(clock),
        .reset(reset_aux),
        .bus  (bus_b.slave)
    );

    gmsk_burst_sequencer #(
        .CLOCKS_PER_SAMPLE (2),
        .SAMPLES_PER_SYMBOL(2)
    ) dut_c (
        .clock(clock),
        .reset(reset_aux),
        .bus  (bus_c.slave)
    );

    typedef struct packed {
        logic ib;
        logic ba;
    } sym_t;

    sym_t exp_q[$];
    logic src_valid[$];
    logic src_bit[$];
    bit   took = 1'b0;

    int cyc = 0;
    int ready_cnt = 0;
    int underrun_cnt = 0;
    int active_syms = 0;

    int cyc_b = 0;
    bit b_done = 1'b0;
    bit c_done = 1'b0;
    int act_c = 0;
    int rdy_c = 0;
    int unr_c = 0;

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Cycle index of dut_a relative to the last reset edge
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    // Monitor for dut_a: timebase pattern, handshake consistency, scoreboard pop
    always @(negedge clock) begin
        if (!reset) begin
            sym_t e;
            check_output("sample_strobe", bus_a.sample_strobe, (cyc % 2) == 1);
            check_output("symbol_strobe", bus_a.symbol_strobe, (cyc > 0) && ((cyc % 8) == 0));
            check_output("underrun", bus_a.underrun, bus_a.payload_ready && !bus_a.payload_valid);
            if (bus_a.payload_ready) begin
                check_output("ready_in_last_sample", (cyc % 8) == 7, 1'b1);
                ready_cnt++;
                took = 1'b1;
            end
            if (bus_a.underrun) underrun_cnt++;
            if (bus_a.symbol_strobe) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '{ib: 1'b0, ba: 1'b0};
                check_output("input_bit", bus_a.input_bit, e.ib);
                check_output("burst_active", bus_a.burst_active, e.ba);
                if (bus_a.burst_active) active_syms++;
            end
        end
    end

    // Payload source for dut_a: one queued entry is presented per request
    always @(posedge clock) begin
        #1;
        if (took) begin
            if (src_valid.size() > 0) begin
                void'(src_valid.pop_front());
                void'(src_bit.pop_front());
            end
            took = 1'b0;
        end
        bus_a.payload_valid = (src_valid.size() > 0) ? src_valid[0] : 1'b0;
        bus_a.payload_bit   = (src_bit.size() > 0) ? src_bit[0] : 1'b0;
    end

    task automatic wait_phase(input int m);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (((cyc % 8) != m) && (n < 64));
        check_count("phase_wait", cyc % 8, m);
    endtask

    // Push the 12-symbol burst expectation (payload 1,0,1,1 after encoding)
    task automatic push_burst();
        logic [11:0] seq;
        seq = 12'h9D2;
        for (int i = 0; i < 12; i++) exp_q.push_back('{ib: seq[11-i], ba: 1'b1});
    endtask

    task automatic load_source(input logic [3:0] v, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            src_valid.push_back(v[3-i]);
            src_bit.push_back(b[3-i]);
        end
    endtask

    // Pulse burst_start for one cycle at the given symbol phase
    task automatic apply_stimulus(input int phase);
        wait_phase(phase);
        push_burst();
        bus_a.burst_start = 1'b1;
        @(posedge clock);
        #1;
        bus_a.burst_start = 1'b0;
    endtask

    initial begin
        int r0, a0, u0;
        bus_a.burst_start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle timebase
        repeat (40) @(posedge clock);

        // Full burst, payload always valid
        r0 = ready_cnt; a0 = active_syms; u0 = underrun_cnt;
        load_source(4'b1111, 4'b1011);
        apply_stimulus(3);
        repeat (16 * 8) @(posedge clock);
        check_count("t2_ready_pulses", ready_cnt - r0, 4);
        check_count("t2_active_syms", active_syms - a0, 12);
        check_count("t2_underruns", underrun_cnt - u0, 0);
        check_count("t2_drained", exp_q.size(), 0);

        // Underrun on the second payload request
        r0 = ready_cnt; a0 = active_syms; u0 = underrun_cnt;
        load_source(4'b1011, 4'b1111);
        apply_stimulus(3);
        repeat (16 * 8) @(posedge clock);
        check_count("t3_ready_pulses", ready_cnt - r0, 4);
        check_count("t3_active_syms", active_syms - a0, 12);
        check_count("t3_underruns", underrun_cnt - u0, 1);
        check_count("t3_drained", exp_q.size(), 0);

        // Start in the last-sample cycle, then a request during payload
        a0 = active_syms;
        load_source(4'b1111, 4'b1011);
        apply_stimulus(7);
        repeat (4 * 8) @(posedge clock);
        wait_phase(3);
        bus_a.burst_start = 1'b1;
        @(posedge clock);
        #1 bus_a.burst_start = 1'b0;
        repeat (20 * 8) @(posedge clock);
        check_count("t4_active_syms", active_syms - a0, 12);
        check_count("t4_drained", exp_q.size(), 0);

        // Reset in the middle of the payload
        load_source(4'b1111, 4'b1011);
        apply_stimulus(3);
        repeat (40) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_output("rst_sample_strobe", bus_a.sample_strobe, 1'b0);
        check_output("rst_symbol_strobe", bus_a.symbol_strobe, 1'b0);
        check_output("rst_input_bit", bus_a.input_bit, 1'b0);
        check_output("rst_burst_active", bus_a.burst_active, 1'b0);
        check_output("rst_payload_ready", bus_a.payload_ready, 1'b0);
        check_output("rst_underrun", bus_a.underrun, 1'b0);
        exp_q.delete();
        src_valid.delete();
        src_bit.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (48) @(posedge clock);

        // Wait for the auxiliary instances
        for (int i = 0; i < 3000 && !(b_done && c_done); i++) @(posedge clock);
        check_count("aux_done", int'(b_done && c_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Default-parameter instance: first sample pulse and symbol period
    always @(posedge clock) cyc_b <= reset_aux ? 0 : cyc_b + 1;

    initial begin
        int last_b = 0;
        int nsym = 0;
        bit first_samp = 1'b1;
        bus_b.burst_start   = 1'b0;
        bus_b.payload_valid = 1'b0;
        bus_b.payload_bit   = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_aux = 1'b0;
        for (int i = 0; i < 2000 && nsym < 3; i++) begin
            @(negedge clock);
            if (bus_b.sample_strobe && first_samp) begin
                check_count("b_first_sample", cyc_b, 3);
                first_samp = 1'b0;
            end
            if (bus_b.symbol_strobe) begin
                check_count("b_symbol_period", cyc_b - last_b, 512);
                last_b = cyc_b;
                nsym++;
            end
        end
        check_count("b_symbols_seen", nsym, 3);
        b_done = 1'b1;
    end

    // Default burst lengths on a fast timebase: 156-symbol burst
    always @(negedge clock) begin
        if (!reset_aux) begin
            if (bus_c.symbol_strobe && bus_c.burst_active) act_c++;
            if (bus_c.payload_ready) rdy_c++;
            if (bus_c.underrun) unr_c++;
        end
    end

    initial begin
        bus_c.burst_start   = 1'b0;
        bus_c.payload_valid = 1'b1;
        bus_c.payload_bit   = 1'b0;
        wait (reset_aux == 1'b0);
        repeat (5) @(posedge clock);
        #1 bus_c.burst_start = 1'b1;
        @(posedge clock);
        #1 bus_c.burst_start = 1'b0;
        repeat (180 * 4) @(posedge clock);
        check_count("c_active_syms", act_c, 156);
        check_count("c_ready_pulses", rdy_c, 142);
        check_count("c_underruns", unr_c, 0);
        c_done = 1'b1;
    end

endmodule
